// File: rtl/switch_pkg.sv
// Shared switch types: MAC and port typedefs, table entry layout and
// the multicast test used by the MAC address table.
package switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = $clog2(NUM_PORTS);

  typedef logic [47:0]       mac_t;
  typedef logic [PORT_W-1:0] port_t;

  // One MAC table entry; seen is only meaningful when aging is built in.
  typedef struct packed {
    logic  valid;
    logic  seen;
    port_t port;
    mac_t  mac;
  } mac_entry_t;

  // The I/G bit is the LSB of the first octet, which sits at bit 40.
  function automatic logic is_multicast(mac_t mac);
    return mac[40];
  endfunction

endpackage

// File: rtl/mac_hash_fold.sv
// XOR-fold of a 48-bit MAC into an INDEX_W-bit table index. Bit i of the
// MAC lands on index bit (i mod INDEX_W), which is the same as XOR-ing all
// INDEX_W-wide chunks together with the top chunk zero-padded.
module mac_hash_fold
  import switch_pkg::*;
#(
  parameter int INDEX_W = 6
) (
  input  mac_t               mac,
  output logic [INDEX_W-1:0] idx
);

  // Fold every MAC bit onto its index position.
  always_comb begin
    idx = '0;
    for (int i = 0; i < 48; i++) begin
      idx[i % INDEX_W] = idx[i % INDEX_W] ^ mac[i];
    end
  end

endmodule

// File: rtl/mac_addr_table.sv
// Direct-mapped, flop-based MAC address table. Each header request looks up
// its destination (forward / flood / filter) and learns its source against
// the ingress port. Optional aging is built in when MAC_AGING_EN is defined.
module mac_addr_table
  import switch_pkg::*;
#(
  parameter int TABLE_DEPTH = 64,
  parameter int AGE_TICKS   = 1_000_000
) (
  input  logic                 switch_clk,
  input  logic                 switch_rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  mac_t                 req_dst_mac_i,
  input  mac_t                 req_src_mac_i,
  input  port_t                req_port_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [NUM_PORTS-1:0] resp_port_mask_o
);

  localparam int INDEX_W = $clog2(TABLE_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

`ifdef MAC_AGING_EN
  localparam logic SEEN_ON_LEARN = 1'b1;
  localparam int   AGE_W         = (AGE_TICKS > 1) ? $clog2(AGE_TICKS) : 1;
`else
  localparam logic SEEN_ON_LEARN = 1'b0;
`endif

  logic [1:0]           state;
  mac_t                 cap_dst;
  mac_t                 cap_src;
  port_t                cap_port;
  mac_entry_t           mac_table [TABLE_DEPTH];
  logic [INDEX_W-1:0]   dst_idx;
  logic [INDEX_W-1:0]   src_idx;
  logic                 accept;
  logic                 learn_en;
  logic                 sweep;
  logic                 dst_match;
  logic                 lookup_hit;
  logic [NUM_PORTS-1:0] lookup_mask;
  logic [NUM_PORTS-1:0] ingress_oh;
  logic [NUM_PORTS-1:0] entry_oh;

  assign req_ready_o = (state == ST_IDLE) && !switch_rst;
  assign accept      = req_valid_i && req_ready_o;
  assign learn_en    = (state == ST_LOOKUP) && !is_multicast(cap_src);

  mac_hash_fold #(.INDEX_W(INDEX_W)) u_dst_fold (
    .mac (cap_dst),
    .idx (dst_idx)
  );

  mac_hash_fold #(.INDEX_W(INDEX_W)) u_src_fold (
    .mac (cap_src),
    .idx (src_idx)
  );

  // Request handshake FSM: IDLE -> LOOKUP -> RESP -> IDLE.
  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (accept) state <= ST_LOOKUP;
        ST_LOOKUP: state <= ST_RESP;
        ST_RESP:   if (resp_valid_o && resp_ready_i) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Capture the header fields on accept; they feed both hash folds.
  always_ff @(posedge switch_clk) begin
    if (accept) begin
      cap_dst  <= req_dst_mac_i;
      cap_src  <= req_src_mac_i;
      cap_port <= req_port_i;
    end
  end

  // Destination lookup against the pre-learn table contents.
  always_comb begin
    ingress_oh                          = '0;
    ingress_oh[cap_port]                = 1'b1;
    entry_oh                            = '0;
    entry_oh[mac_table[dst_idx].port]   = 1'b1;
    dst_match   = mac_table[dst_idx].valid && (mac_table[dst_idx].mac == cap_dst);
    lookup_hit  = 1'b0;
    lookup_mask = ~ingress_oh;
    if (!is_multicast(cap_dst) && dst_match) begin
      lookup_hit  = 1'b1;
      lookup_mask = (mac_table[dst_idx].port == cap_port) ? '0 : entry_oh;
    end
  end

  // Response registers: loaded at the end of LOOKUP, held under backpressure.
  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      resp_valid_o     <= 1'b0;
      resp_hit_o       <= 1'b0;
      resp_port_mask_o <= '0;
    end else if (state == ST_LOOKUP) begin
      resp_valid_o     <= 1'b1;
      resp_hit_o       <= lookup_hit;
      resp_port_mask_o <= lookup_mask;
    end else if (resp_valid_o && resp_ready_i) begin
      resp_valid_o     <= 1'b0;
    end
  end

`ifdef MAC_AGING_EN
  logic [AGE_W-1:0] age_cnt;

  assign sweep = (age_cnt == AGE_W'(AGE_TICKS - 1));

  // Free-running aging tick counter; a sweep fires on the wrap cycle.
  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      age_cnt <= '0;
    end else if (sweep) begin
      age_cnt <= '0;
    end else begin
      age_cnt <= age_cnt + 1'b1;
    end
  end
`else
  assign sweep = 1'b0;
`endif

  // Table update: sweep first, then the learn write so it wins its entry.
  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        mac_table[i] <= '0;
      end
    end else begin
      if (sweep) begin
        for (int i = 0; i < TABLE_DEPTH; i++) begin
          if (!mac_table[i].seen) mac_table[i].valid <= 1'b0;
          mac_table[i].seen <= 1'b0;
        end
      end
      if (learn_en) begin
        mac_table[src_idx] <= '{valid: 1'b1, seen: SEEN_ON_LEARN,
                                port: cap_port, mac: cap_src};
      end
    end
  end

endmodule

// File: tb/tb_mac_addr_table.sv
// Directed testbench for mac_addr_table with a 4-entry table so that index
// collisions are easy to build. Aging scenarios run when MAC_AGING_EN is set.
module tb_mac_addr_table;
  import switch_pkg::*;

  localparam mac_t MAC_A  = 48'h0011_2233_4400;  // idx 0
  localparam mac_t MAC_B  = 48'h0011_2233_4401;  // idx 1
  localparam mac_t MAC_E  = 48'h0011_2233_4405;  // idx 0, collides with A
  localparam mac_t MAC_D1 = 48'h1020_3040_5000;  // never learned
  localparam mac_t MAC_BC = 48'hFFFF_FFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reqValid = 1'b0;
  logic       reqReady;
  mac_t       reqDst = '0;
  mac_t       reqSrc = '0;
  port_t      reqPort = '0;
  logic       respValid;
  logic       respReady = 1'b1;
  logic       respHit;
  logic [3:0] respMask;

  int checkCount = 0;
  int failCount  = 0;
  int edgeCnt    = 0;

  mac_addr_table #(.TABLE_DEPTH(4), .AGE_TICKS(100)) dut (
    .switch_clk       (clk),
    .switch_rst       (rst),
    .req_valid_i      (reqValid),
    .req_ready_o      (reqReady),
    .req_dst_mac_i    (reqDst),
    .req_src_mac_i    (reqSrc),
    .req_port_i       (reqPort),
    .resp_valid_o     (respValid),
    .resp_ready_i     (respReady),
    .resp_hit_o       (respHit),
    .resp_port_mask_o (respMask)
  );

  // 10 ns switch clock.
  always #5 clk = ~clk;

  // Mirrors the aging tick position: after each edge edgeCnt % 100 is the phase.
  always @(posedge clk) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  // Hard stop in case something hangs.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one header and check the response; completes the handshake only
  // when respReady is already high.
  task automatic applyStimulus(input string tag, input mac_t src, input mac_t dst,
                               input port_t port, input logic expHit,
                               input logic [3:0] expMask);
    int waitCycles = 0;
    while (!reqReady && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput({tag, "_ready"}, 64'(reqReady), 64'd1);
    reqSrc   = src;
    reqDst   = dst;
    reqPort  = port;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    checkOutput({tag, "_lookup_valid"}, 64'(respValid), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_resp_valid"}, 64'(respValid), 64'd1);
    checkOutput({tag, "_hit"}, 64'(respHit), 64'(expHit));
    checkOutput({tag, "_mask"}, 64'(respMask), 64'(expMask));
    if (respReady) begin
      @(posedge clk); #1;
      checkOutput({tag, "_resp_done"}, 64'(respValid), 64'd0);
      checkOutput({tag, "_ready_back"}, 64'(reqReady), 64'd1);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
    checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
    checkOutput("rst_resp_hit", 64'(respHit), 64'd0);
    checkOutput("rst_resp_mask", 64'(respMask), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", 64'(reqReady), 64'd1);

    // Cold miss floods, then learned forward, broadcast and filter.
    applyStimulus("cold_miss", MAC_A, MAC_D1, 2'd0, 1'b0, 4'b1110);
    applyStimulus("learned_fwd", MAC_B, MAC_A, 2'd1, 1'b1, 4'b0001);
    applyStimulus("broadcast", MAC_BC, MAC_BC, 2'd2, 1'b0, 4'b1011);
    applyStimulus("filter", MAC_B, MAC_B, 2'd1, 1'b1, 4'b0000);

    // Collision: E shares index 0 with A and evicts it.
    applyStimulus("evict_learn", MAC_E, MAC_D1, 2'd3, 1'b0, 4'b0111);
    applyStimulus("evicted_miss", MAC_BC, MAC_A, 2'd1, 1'b0, 4'b1101);

    // Station move: B relearned on port 3.
    applyStimulus("move_learn", MAC_B, MAC_D1, 2'd3, 1'b0, 4'b0111);
    applyStimulus("move_fwd", MAC_BC, MAC_B, 2'd0, 1'b1, 4'b1000);

    // Backpressure: response held for 5 cycles.
    respReady = 1'b0;
    applyStimulus("bp", MAC_BC, MAC_E, 2'd1, 1'b1, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", 64'(respValid), 64'd1);
      checkOutput("bp_hold_hit", 64'(respHit), 64'd1);
      checkOutput("bp_hold_mask", 64'(respMask), 64'b1000);
      checkOutput("bp_hold_ready", 64'(reqReady), 64'd0);
    end
    respReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", 64'(respValid), 64'd0);
    checkOutput("bp_release_ready", 64'(reqReady), 64'd1);

    // Reset in the middle of RESP drops the response and clears the table.
    respReady = 1'b0;
    applyStimulus("midrst", MAC_B, MAC_B, 2'd0, 1'b1, 4'b1000);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_valid", 64'(respValid), 64'd0);
    checkOutput("midrst_hit", 64'(respHit), 64'd0);
    checkOutput("midrst_mask", 64'(respMask), 64'd0);
    checkOutput("midrst_ready", 64'(reqReady), 64'd0);
    rst = 1'b0;
    respReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("postrst_no_resp", 64'(respValid), 64'd0);
    applyStimulus("postrst_cleared", MAC_BC, MAC_E, 2'd1, 1'b0, 4'b1101);

`ifdef MAC_AGING_EN
    // Unrefreshed station ages out within two sweeps.
    applyStimulus("age_learn", MAC_A, MAC_D1, 2'd0, 1'b0, 4'b1110);
    repeat (250) @(posedge clk);
    #1;
    applyStimulus("age_expired", MAC_BC, MAC_A, 2'd1, 1'b0, 4'b1101);

    // Align so the learn write lands on the sweep cycle.
    begin
      int waitCycles = 0;
      while (!(reqReady && (edgeCnt % 100 == 98)) && waitCycles < 300) begin
        @(posedge clk); #1;
        waitCycles++;
      end
      checkOutput("age_align", 64'(edgeCnt % 100), 64'd98);
    end
    applyStimulus("age_sweep_learn", MAC_A, MAC_D1, 2'd2, 1'b0, 4'b1011);
    applyStimulus("age_survive_now", MAC_BC, MAC_A, 2'd0, 1'b1, 4'b0100);
    repeat (100) @(posedge clk);
    #1;
    applyStimulus("age_survive_next", MAC_BC, MAC_A, 2'd0, 1'b1, 4'b0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
